// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//
// Purpose: bundles every datapath-facing signal of the pipeline stall/flush
// controller so the datapath and the controller connect through one port.
//
// Signal summary
//   Datapath -> controller (inputs of the controller)
//     id_src1, id_src2 [3:0]  source registers of the instruction in ID
//     id_two_src              id_src2 is a real operand
//     id_valid                ID holds a real instruction
//     exe_wb_en, exe_mem_r_en ID/EX register outputs (writes back / is a load)
//     exe_wb_dest [3:0]       ID/EX destination register
//     mem_wb_en               EX/MEM register output
//     mem_wb_dest [3:0]       EX/MEM destination register
//     branch_taken            EX resolved a taken branch this cycle
//     mem_req                 MEM stage is issuing a data access
//     mem_ready               data memory completes the access this cycle
//   Controller -> datapath (outputs of the controller)
//     pc_freeze, ifid_freeze  hold PC and the IF/ID register
//     idex_bubble             load zero control bits into ID/EX
//     ifid_flush, idex_flush  clear the register at the next edge
//     pipe_stall              hold every stage register, PC included
//     mem_err                 sticky data-memory timeout flag
//     stall_cnt, flush_cnt    saturating 16-bit event counters
//
// Modports
//   master : datapath side (drives stage-register fields, consumes controls)
//   slave  : hazard controller side
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
  logic [3:0]  id_src1;
  logic [3:0]  id_src2;
  logic        id_two_src;
  logic        id_valid;
  logic        exe_wb_en;
  logic        exe_mem_r_en;
  logic [3:0]  exe_wb_dest;
  logic        mem_wb_en;
  logic [3:0]  mem_wb_dest;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;

  logic        pc_freeze;
  logic        ifid_freeze;
  logic        idex_bubble;
  logic        ifid_flush;
  logic        idex_flush;
  logic        pipe_stall;
  logic        mem_err;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output id_src1, id_src2, id_two_src, id_valid,
    output exe_wb_en, exe_mem_r_en, exe_wb_dest,
    output mem_wb_en, mem_wb_dest,
    output branch_taken, mem_req, mem_ready,
    input  pc_freeze, ifid_freeze, idex_bubble, ifid_flush, idex_flush,
    input  pipe_stall, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_src1, id_src2, id_two_src, id_valid,
    input  exe_wb_en, exe_mem_r_en, exe_wb_dest,
    input  mem_wb_en, mem_wb_dest,
    input  branch_taken, mem_req, mem_ready,
    output pc_freeze, ifid_freeze, idex_bubble, ifid_flush, idex_flush,
    output pipe_stall, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose: central stall/flush controller for the 5-stage pipeline. Detects
// read-after-write hazards against the instructions in EX and MEM, inserts
// bubbles into ID/EX, squashes the two wrong-path instructions behind a taken
// branch, and freezes the whole pipe while a data-memory access is pending
// (with a timeout that raises a sticky error). Also counts stall and flush
// cycles in saturating 16-bit counters.
//
// Parameters
//   FORWARD_EN  1: forwarding present, only load-use hazards stall
//               0: stall on any RAW match in EX or MEM
//   MEM_TIMEOUT maximum memory-wait length in cycles (2..255)
//
// Ports
//   clk  clock
//   rst  asynchronous, active-high reset
//   hif  datapath bundle (slave side), see pipeline_hazard_ctrl_if
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter bit          FORWARD_EN  = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hif
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // wait_cnt value in the last permitted MEM_WAIT cycle. Entry cycle (RUN)
  // plus MEM_TIMEOUT-1 MEM_WAIT cycles gives MEM_TIMEOUT stalled cycles.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t      state_q,      state_d;
  logic [7:0]  wait_cnt_q,   wait_cnt_d;
  logic        flush_pend_q, flush_pend_d;
  logic        mem_err_q,    mem_err_d;
  logic [15:0] stall_cnt_q,  stall_cnt_d;
  logic [15:0] flush_cnt_q,  flush_cnt_d;

  // Unmasked control decisions (masked by rst at the outputs)
  logic pipe_stall;
  logic flush_now;
  logic pc_freeze;
  logic idex_bubble;

  // -------------------------------------------------------------------------
  // Data hazard detection, one comparator pair per source operand
  // -------------------------------------------------------------------------
  logic [1:0][3:0] src;
  logic [1:0]      src_used;
  logic [1:0]      src_hz;
  logic            hz;

  assign src[0]      = hif.id_src1;
  assign src[1]      = hif.id_src2;
  assign src_used[0] = 1'b1;
  assign src_used[1] = hif.id_two_src;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic exe_match;
      logic mem_match;

      assign exe_match = hif.exe_wb_en && (src[gi] == hif.exe_wb_dest);
      assign mem_match = hif.mem_wb_en && (src[gi] == hif.mem_wb_dest);

      // With forwarding only a load in EX cannot be bypassed in time; without
      // it any pending write in EX or MEM must complete first.
      assign src_hz[gi] = src_used[gi] &&
                          ((exe_match && (hif.exe_mem_r_en || !FORWARD_EN)) ||
                           (mem_match && !FORWARD_EN));
    end
  endgenerate

  assign hz = hif.id_valid && (|src_hz);

  // -------------------------------------------------------------------------
  // Next-state and control decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    flush_pend_d = flush_pend_q;
    mem_err_d    = mem_err_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    pipe_stall   = 1'b0;
    flush_now    = 1'b0;
    pc_freeze    = 1'b0;
    idex_bubble  = 1'b0;

    case (state_q)
      RUN: begin
        // The first cycle of a slow access is already a stall cycle.
        if (hif.mem_req && !hif.mem_ready) begin
          pipe_stall = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd0;
        end
      end
      MEM_WAIT: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (hif.mem_ready) begin
          state_d = RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Give up: release the pipe this cycle and remember the failure.
          state_d   = RUN;
          mem_err_d = 1'b1;
        end else begin
          pipe_stall = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    // Memory stall dominates; a branch resolved while frozen is parked in
    // flush_pend and issued in the first cycle the pipe moves again.
    if (pipe_stall) begin
      pc_freeze = 1'b1;
      if (hif.branch_taken) begin
        flush_pend_d = 1'b1;
      end
    end else begin
      flush_pend_d = 1'b0;
      if (hif.branch_taken || flush_pend_q) begin
        // The instruction in ID is wrong-path, so its hazard is irrelevant.
        flush_now = 1'b1;
      end else if (hz) begin
        pc_freeze   = 1'b1;
        idex_bubble = 1'b1;
      end
    end

    if (pc_freeze && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (flush_now && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      wait_cnt_q   <= 8'd0;
      flush_pend_q <= 1'b0;
      mem_err_q    <= 1'b0;
      stall_cnt_q  <= 16'd0;
      flush_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      flush_pend_q <= flush_pend_d;
      mem_err_q    <= mem_err_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: combinational controls are forced low while rst is asserted so
  // the datapath sees a quiet controller regardless of its own inputs.
  // -------------------------------------------------------------------------
  assign hif.pipe_stall  = !rst && pipe_stall;
  assign hif.pc_freeze   = !rst && pc_freeze;
  assign hif.ifid_freeze = !rst && pc_freeze;
  assign hif.idex_bubble = !rst && idex_bubble;
  assign hif.ifid_flush  = !rst && flush_now;
  assign hif.idex_flush  = !rst && flush_now;
  assign hif.mem_err     = mem_err_q;
  assign hif.stall_cnt   = stall_cnt_q;
  assign hif.flush_cnt   = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage ARM pipeline. It drives the freeze, bubble and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It detects register read-after-write hazards, inserts bubbles, squashes wrong-path instructions on a taken branch, and holds the whole pipe while a data-memory access is outstanding. It sits beside the datapath, takes stage-register fields as inputs, and exposes saturating performance counters.

## Interface
- FORWARD_EN, 1: 1 = forwarding unit present, so only load-use hazards stall; 0 = stall on any RAW match in EX or MEM.
- MEM_TIMEOUT, 64: maximum MEM_WAIT cycles before abort; range 2..255.
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- id_src1, id_src2  in  4 each  source registers of the instruction in ID
- id_two_src  in  1  id_src2 is a real operand
- id_valid  in  1  ID holds a real instruction
- exe_wb_en, exe_mem_r_en  in  1 each  ID/EX register outputs
- exe_wb_dest  in  4  ID/EX destination register
- mem_wb_en  in  1  EX/MEM register output
- mem_wb_dest  in  4  EX/MEM destination register
- branch_taken  in  1  EX resolved a taken branch this cycle
- mem_req  in  1  MEM stage is issuing a data access (read or write)
- mem_ready  in  1  data memory completes the access this cycle
- pc_freeze, ifid_freeze  out  1 each  hold PC and the IF/ID register
- idex_bubble  out  1  load zero control bits into ID/EX
- ifid_flush, idex_flush  out  1 each  clear the register at the next edge
- pipe_stall  out  1  hold every stage register, PC included
- mem_err  out  1  sticky timeout flag
- stall_cnt, flush_cnt  out  16 each  saturating event counters

## Operation
- FSM states:
  - RUN
    - RUN→MEM_WAIT when mem_req & !mem_ready.
  - MEM_WAIT
    - MEM_WAIT→RUN when mem_ready, or when wait_cnt reaches MEM_TIMEOUT−1.
    - The timeout exit sets mem_err, which clears only on rst.
- wait_cnt, 8 bits:
  - Cleared on entry to MEM_WAIT.
  - Increments each MEM_WAIT cycle.
- pipe_stall = (RUN & mem_req & !mem_ready) | (MEM_WAIT & !mem_ready & !timeout_exit).
- Data hazard (hz), qualified by id_valid; src2 participates only if id_two_src:
  - FORWARD_EN=0: any source equals exe_wb_dest with exe_wb_en, or equals mem_wb_dest with mem_wb_en.
  - FORWARD_EN=1: any source equals exe_wb_dest with exe_wb_en & exe_mem_r_en.
- Priority: pipe_stall > flush > hz.
  - While pipe_stall: pc_freeze = ifid_freeze = 1; idex_bubble = ifid_flush = idex_flush = 0.
  - Otherwise, if branch_taken | flush_pend: ifid_flush = idex_flush = 1; hz is ignored because the wrong-path instruction is squashed.
  - Otherwise, if hz: pc_freeze = ifid_freeze = idex_bubble = 1.
- flush_pend register:
  - Set when branch_taken coincides with pipe_stall, so the flush is deferred rather than lost.
  - Cleared on the first non-stalled cycle; the flush is issued in that cycle.
- stall_cnt: +1 every cycle pc_freeze = 1.
- flush_cnt: +1 every cycle the flush is issued.
- Both counters saturate at 0xFFFF and never wrap.

## Timing
- Reset: state = RUN, wait_cnt = 0, flush_pend = 0, mem_err = 0, stall_cnt = flush_cnt = 0.
- During reset all combinational outputs are 0, forced while rst is high.
- Control outputs are combinational from inputs and state, with zero latency; they act at the next clk edge.
- Counters, FSM and flush_pend update on posedge clk.
- hz persists while the producer remains in EX. A load-use hazard therefore costs exactly 1 bubble.
- A taken branch costs 2 squashed instructions.
- Memory wait of N cycles (mem_ready arrives N cycles after mem_req, N ≥ 1) stalls exactly N cycles.
- Timeout releases the stall after MEM_TIMEOUT cycles total.
- rst asserted mid-MEM_WAIT returns to RUN immediately; a pending flush is discarded.

## Test plan
- Load-use, FORWARD_EN=1: exe_mem_r_en=1, exe_wb_en=1, exe_wb_dest=3, id_src1=3, id_valid=1 for one cycle → pc_freeze = idex_bubble = 1 for that cycle; stall_cnt 0→1.
  - Same case with id_src2=3, id_two_src=0 → no stall.
- RAW, FORWARD_EN=0: mem_wb_en=1, mem_wb_dest=5, id_src2=5, id_two_src=1 → stall asserted.
  - Same case with mem_wb_en=0 → no stall.
- Branch: branch_taken pulse while hz=1 → ifid_flush = idex_flush = 1, idex_bubble = 0; flush_cnt = 1.
- Memory wait: mem_req=1 and mem_ready held low 3 cycles then high → pipe_stall high exactly 3 cycles, FSM back in RUN.
  - Assert branch_taken in stall cycle 2 → flush issued in the first cycle after release.
- Timeout, MEM_TIMEOUT=4: mem_ready never asserts → pipe_stall drops after 4 cycles; mem_err = 1 and stays set until rst.
- Saturation and reset: hold hz for 70000 cycles → stall_cnt = 0xFFFF.
  - Assert rst during MEM_WAIT → all outputs and counters 0 asynchronously.
